// File: rtl/phase_step_if.sv
// Signal bundle between a phase-detector/firmware side and phase_step_ctrl.
// The design side is the slave; whoever drives votes and override holds the master end.
interface phase_step_if;
    logic       en;
    logic       early;
    logic       late;
    logic       manual_en;
    logic [1:0] manual_sel;
    logic [1:0] control;
    logic       step_pulse;
    logic       step_dir;
    logic       busy;
    logic [1:0] state;

    modport master (
        output en, early, late, manual_en, manual_sel,
        input  control, step_pulse, step_dir, busy, state
    );

    modport slave (
        input  en, early, late, manual_en, manual_sel,
        output control, step_pulse, step_dir, busy, state
    );
endinterface

// File: rtl/phase_step_ctrl.sv
// Early/late vote integrator that steps a 2-bit phase select modulo 4,
// with a post-step hold-off window and a firmware override.
module phase_step_ctrl #(
    parameter int VOTE_THRESH = 4,
    parameter int HOLDOFF     = 8,
    parameter int INIT_PHASE  = 0
) (
    input  logic         clk,
    input  logic         rst,
    phase_step_if.slave  bus
);
    localparam int CW = $clog2(VOTE_THRESH) + 2;
    localparam logic signed [CW-1:0] THRESH_P = CW'(VOTE_THRESH);
    localparam logic signed [CW-1:0] THRESH_N = -THRESH_P;
    localparam logic [7:0] HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state;
    logic signed [CW-1:0]   count;
    logic signed [CW-1:0]   vote;
    logic signed [CW-1:0]   sum;
    logic [7:0]             timer;
    logic [1:0]             control;
    logic                   step_pulse;
    logic                   step_dir;
    logic                   busy;

    // Both votes at once cancel to a null vote rather than being an error.
    always_comb begin
        vote = '0;
        if (bus.early && !bus.late)
            vote = {{(CW-1){1'b0}}, 1'b1};
        else if (bus.late && !bus.early)
            vote = '1;
        sum = count + vote;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            timer      <= '0;
            control    <= 2'(INIT_PHASE);
            step_pulse <= 1'b0;
            step_dir   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (bus.manual_en) begin
                control <= bus.manual_sel;
                count   <= '0;
                state   <= IDLE;
                busy    <= 1'b0;
            end else if (!bus.en) begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        count <= '0;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (sum == THRESH_P || sum == THRESH_N) begin
                            control    <= (sum == THRESH_P) ? control + 2'd1 : control - 2'd1;
                            step_dir   <= (sum == THRESH_P);
                            step_pulse <= 1'b1;
                            count      <= '0;
                            if (HOLDOFF == 0) begin
                                state <= TRACK;
                            end else begin
                                state <= HOLD;
                                busy  <= 1'b1;
                                timer <= HOLD_LOAD;
                            end
                        end else begin
                            count <= sum;
                        end
                    end
                    HOLD: begin
                        // Timer is loaded with HOLDOFF-1 so busy spans exactly HOLDOFF cycles.
                        count <= '0;
                        if (timer == 8'd0) begin
                            busy  <= 1'b0;
                            state <= TRACK;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                    default: begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.control    = control;
    assign bus.step_pulse = step_pulse;
    assign bus.step_dir   = step_dir;
    assign bus.busy       = busy;
    assign bus.state      = state;
endmodule
